// File: rtl/ascon_cmd_loader.sv
// ascon_cmd_loader: decodes opcode headers from the SPI word stream and
// assembles key / nonce / data payloads for the Ascon core, then issues a
// one-cycle start pulse with encrypt/decrypt mode.
//
// Ports:
//   clk        system clock (all logic on posedge)
//   rst        synchronous active-high reset
//   word_in    32-bit parallel word from the serial-to-parallel stage
//   word_valid single-cycle strobe qualifying word_in
//   core_busy  core is processing; blocks start
//   key        assembled key (first payload word lands in the MSBs)
//   nonce      assembled nonce
//   data       assembled data block
//   loaded     sticky {data, nonce, key} loaded flags
//   start      one-cycle start pulse
//   mode       0 = encrypt, 1 = decrypt; held after start
//   err        sticky protocol error, cleared by opcode 0xA0
module ascon_cmd_loader #(
  parameter int unsigned KEY_WORDS   = 4,
  parameter int unsigned NONCE_WORDS = 4,
  parameter int unsigned DATA_WORDS  = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [31:0]               word_in,
  input  logic                      word_valid,
  input  logic                      core_busy,
  output logic [32*KEY_WORDS-1:0]   key,
  output logic [32*NONCE_WORDS-1:0] nonce,
  output logic [32*DATA_WORDS-1:0]  data,
  output logic [2:0]                loaded,
  output logic                      start,
  output logic                      mode,
  output logic                      err
);

  localparam int unsigned CNT_W   = 2;
  localparam int unsigned KEY_W   = 32 * KEY_WORDS;
  localparam int unsigned NONCE_W = 32 * NONCE_WORDS;
  localparam int unsigned DATA_W  = 32 * DATA_WORDS;

  localparam logic [7:0] OP_CLR   = 8'hA0;
  localparam logic [7:0] OP_KEY   = 8'hA1;
  localparam logic [7:0] OP_NONCE = 8'hA2;
  localparam logic [7:0] OP_DATA  = 8'hA3;
  localparam logic [7:0] OP_ENC   = 8'hA4;
  localparam logic [7:0] OP_DEC   = 8'hA5;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_KEY   = 2'd1,
    S_NONCE = 2'd2,
    S_DATA  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [KEY_W-1:0]   key_q, key_d;
  logic [NONCE_W-1:0] nonce_q, nonce_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [2:0]         loaded_q, loaded_d;
  logic               start_q, start_d;
  logic               mode_q, mode_d;
  logic               err_q, err_d;

  logic [7:0] opcode;
  assign opcode = word_in[31:24];

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (word_valid) begin
      case (state_q)
        S_IDLE: begin
          case (opcode)
            OP_KEY:   state_d = S_KEY;
            OP_NONCE: state_d = S_NONCE;
            OP_DATA:  state_d = S_DATA;
            default:  state_d = S_IDLE;
          endcase
        end
        S_KEY:   if (cnt_q == CNT_W'(KEY_WORDS - 1))   state_d = S_IDLE;
        S_NONCE: if (cnt_q == CNT_W'(NONCE_WORDS - 1)) state_d = S_IDLE;
        S_DATA:  if (cnt_q == CNT_W'(DATA_WORDS - 1))  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Output / datapath next values; payload word k lands at slot WORDS-1-k
  always_comb begin
    cnt_d    = cnt_q;
    key_d    = key_q;
    nonce_d  = nonce_q;
    data_d   = data_q;
    loaded_d = loaded_q;
    start_d  = 1'b0;
    mode_d   = mode_q;
    err_d    = err_q;
    if (word_valid) begin
      case (state_q)
        S_IDLE: begin
          case (opcode)
            OP_CLR: err_d = 1'b0;
            OP_KEY: begin
              loaded_d[0] = 1'b0;
              cnt_d       = '0;
            end
            OP_NONCE: begin
              loaded_d[1] = 1'b0;
              cnt_d       = '0;
            end
            OP_DATA: begin
              loaded_d[2] = 1'b0;
              cnt_d       = '0;
            end
            OP_ENC, OP_DEC: begin
              if (loaded_q == 3'b111 && !core_busy) begin
                start_d     = 1'b1;
                mode_d      = opcode[0];
                loaded_d[2] = 1'b0;
              end else begin
                err_d = 1'b1;
              end
            end
            default: err_d = 1'b1;
          endcase
        end
        S_KEY: begin
          for (int unsigned i = 0; i < KEY_WORDS; i++) begin
            if (cnt_q == CNT_W'(KEY_WORDS - 1 - i)) key_d[i*32 +: 32] = word_in;
          end
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(KEY_WORDS - 1)) loaded_d[0] = 1'b1;
        end
        S_NONCE: begin
          for (int unsigned i = 0; i < NONCE_WORDS; i++) begin
            if (cnt_q == CNT_W'(NONCE_WORDS - 1 - i)) nonce_d[i*32 +: 32] = word_in;
          end
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(NONCE_WORDS - 1)) loaded_d[1] = 1'b1;
        end
        S_DATA: begin
          for (int unsigned i = 0; i < DATA_WORDS; i++) begin
            if (cnt_q == CNT_W'(DATA_WORDS - 1 - i)) data_d[i*32 +: 32] = word_in;
          end
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DATA_WORDS - 1)) loaded_d[2] = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Datapath / output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      key_q    <= '0;
      nonce_q  <= '0;
      data_q   <= '0;
      loaded_q <= '0;
      start_q  <= 1'b0;
      mode_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      key_q    <= key_d;
      nonce_q  <= nonce_d;
      data_q   <= data_d;
      loaded_q <= loaded_d;
      start_q  <= start_d;
      mode_q   <= mode_d;
      err_q    <= err_d;
    end
  end

  assign key    = key_q;
  assign nonce  = nonce_q;
  assign data   = data_q;
  assign loaded = loaded_q;
  assign start  = start_q;
  assign mode   = mode_q;
  assign err    = err_q;

endmodule

// File: doc/ascon_cmd_loader.md
# ascon_cmd_loader

Command/payload loader sitting directly downstream of the SPI serial-to-parallel converter. It consumes the 32-bit words that converter produces, one per word-valid strobe. It decodes an opcode header word and assembles the following payload words into the 128-bit key, 128-bit nonce and 64-bit data block for the Ascon core. It then issues a one-cycle start pulse with encrypt/decrypt mode, and flags protocol errors.

## Interface
Parameters:
- KEY_WORDS, 4, payload words for a key load (128 bits)
- NONCE_WORDS, 4, payload words for a nonce load (128 bits)
- DATA_WORDS, 2, payload words for a data load (64 bits)

Ports:
- clk  input  1  system clock; one clock domain, all logic on posedge clk
- rst  input  1  synchronous, active-high reset
- word_in  input  32  parallel word from the serial-to-parallel stage
- word_valid  input  1  single-cycle strobe: word_in holds a complete new word
- core_busy  input  1  Ascon core is processing; high blocks start
- key  output  128  assembled key
- nonce  output  128  assembled nonce
- data  output  64  assembled data block
- loaded  output  3  sticky flags {data, nonce, key} loaded
- start  output  1  one-cycle start pulse to core
- mode  output  1  0 = encrypt, 1 = decrypt; valid with start, held after it
- err  output  1  sticky protocol error

## Operation
- Opcode decode uses word_in[31:24]. Bits [23:0] of a header word are ignored.
  - 0xA0: clear err
  - 0xA1: load key
  - 0xA2: load nonce
  - 0xA3: load data
  - 0xA4: start encrypt
  - 0xA5: start decrypt
  - any other value: set err, remain IDLE
- FSM states: IDLE, KEY, NONCE, DATA.
  - IDLE + 0xA1/A2/A3: go to KEY/NONCE/DATA and clear the word counter.
  - In a load state, every word_valid word is payload, whatever its value.
  - After KEY_WORDS/NONCE_WORDS/DATA_WORDS payload words: set the matching loaded bit and return to IDLE.
- Payload ordering: the first word fills the most-significant 32 bits (key[127:96] first; data[63:32] first). Each following word fills the next lower 32 bits.
- When a load begins, clear the matching loaded bit. The target register keeps its old bits until each one is overwritten.
- Start (0xA4/0xA5) in IDLE:
  - If loaded == 3'b111 and core_busy == 0: pulse start, latch mode, clear loaded[2] (data is consumed). Key and nonce stay loaded.
  - Otherwise: set err, no start, mode unchanged.
- err is set only by the conditions above. It clears only on 0xA0 or rst. Setting takes priority over nothing else: err does not block further commands.
- Word counter is 2 bits wide, sized for the largest payload, and is reset to 0 on entry to each load state.

## Timing
- Reset values: key = 0, nonce = 0, data = 0, loaded = 0, start = 0, mode = 0, err = 0, state IDLE, counter 0.
- Outputs are registered. A payload word written at edge N is visible on key/nonce/data after edge N.
- The loaded bit rises at the same edge that writes the final payload word.
- start is high for exactly one cycle, in the cycle after the edge that accepts the start header.
- Back-to-back word_valid on consecutive cycles is fully supported. There is no backpressure and no word is dropped.
- word_valid low: no state change. Cycles between strobes are unbounded.
- core_busy is sampled at the edge that accepts the start header.
- rst takes priority over word_valid in the same cycle. Reset mid-load abandons the load and clears all registers.
- A header received while start is high is processed normally.

## Test plan
- Reset, then send A1000000, 00112233, 44556677, 8899AABB, CCDDEEFF -> key = 00112233_44556677_8899AABB_CCDDEEFF; loaded = 3'b001.
- Load a nonce (4 words) and data 01234567, 89ABCDEF, then send A5000000 with core_busy = 0 -> start pulses for 1 cycle; mode = 1; loaded returns to 3'b011; err = 0.
- Send A4000000 with loaded = 3'b011 -> no start, err = 1. Then send A0000000 -> err = 0.
- Send A3000000, then A1000000 as payload, then 5 -> data = A1000000_00000005; state returns to IDLE (opcode-valued payload is not decoded).
- Strobe a full key load on 5 consecutive cycles, asserting rst during the 3rd payload word -> all outputs 0. A following fresh key load completes correctly.
- Send header 7F000000 -> err = 1, state stays IDLE. Send A4000000 with all loaded but core_busy = 1 -> no start, err stays 1.
